// File: rtl/bf16_dot_if.sv
// Handshake and FMA operand bundle for the bf16 dot-product sequencer.
// master: job source / result sink / FMA side; slave: the sequencer.
interface bf16_dot_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] vec_len;
    logic [15:0]      init_acc;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic [15:0]      fma_a;
    logic [15:0]      fma_b;
    logic [15:0]      fma_c;
    logic [15:0]      fma_result;
    logic             fma_zero;
    logic             fma_underflow;
    logic             fma_overflow;
    logic             fma_qnan;
    logic             fma_snan;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_result;
    logic [4:0]       out_flags;
    logic             busy;

    modport master (
        output start, vec_len, init_acc,
        output in_valid, in_a, in_b,
        output fma_result, fma_zero, fma_underflow,
        output fma_overflow, fma_qnan, fma_snan,
        output out_ready,
        input  in_ready, fma_a, fma_b, fma_c,
        input  out_valid, out_result, out_flags, busy
    );

    modport slave (
        input  start, vec_len, init_acc,
        input  in_valid, in_a, in_b,
        input  fma_result, fma_underflow,
        input  fma_overflow, fma_qnan, fma_snan,
        input  out_ready,
        output in_ready, fma_a, fma_b, fma_c,
        output out_valid, out_result, out_flags, busy
    );
endinterface

// File: rtl/bf16_dot_sequencer.sv
// Streams bf16 pairs through an external FMA, feeding each result back as C.
// Option BF16_DOT_NAN_EARLY_EN: after a NaN, drain the rest of the job.
module bf16_dot_sequencer #(
    parameter int LEN_W   = 8,
    parameter int FMA_LAT = 1
) (
    input logic       clk,
    input logic       rst,
    bf16_dot_if.slave bus
);
    localparam int              WC_W    = (FMA_LAT > 1) ? $clog2(FMA_LAT) : 1;
    localparam logic [WC_W-1:0] WC_INIT = WC_W'(FMA_LAT - 1);

`ifdef BF16_DOT_NAN_EARLY_EN
    localparam logic [15:0] QNAN = 16'h7FC0;
    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_WAIT, S_DONE, S_DRAIN
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_ACCEPT, S_WAIT, S_DONE
    } state_t;
`endif

    state_t           r_state;
    logic [LEN_W-1:0] r_rem;
    logic [WC_W-1:0]  r_wcnt;
    logic [15:0]      r_acc;
    logic [3:0]       r_sticky;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [15:0]      r_fma_a;
    logic [15:0]      r_fma_b;
    logic [15:0]      r_fma_c;
    logic [15:0]      r_out_result;
    logic [4:0]       r_out_flags;

    logic [3:0] w_flags;
    logic [3:0] w_sticky;
    logic       w_last;

    // Idle FMA flags float at X, so only a strict 1 counts.
    assign w_flags = {bus.fma_snan     === 1'b1,
                      bus.fma_qnan     === 1'b1,
                      bus.fma_overflow === 1'b1,
                      bus.fma_underflow === 1'b1};
    assign w_sticky = r_sticky | w_flags;
    assign w_last   = (r_rem == LEN_W'(1));

    function automatic logic [4:0] mk_flags(input logic [3:0]  s,
                                            input logic [15:0] v);
        return {s, v[14:0] == 15'd0};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rem        <= '0;
            r_wcnt       <= '0;
            r_acc        <= '0;
            r_sticky     <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_fma_a      <= '0;
            r_fma_b      <= '0;
            r_fma_c      <= '0;
            r_out_result <= '0;
            r_out_flags  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_rem    <= bus.vec_len;
                        r_acc    <= bus.init_acc;
                        r_sticky <= '0;
                        r_busy   <= 1'b1;
                        if (bus.vec_len == '0) begin
                            r_state      <= S_DONE;
                            r_out_valid  <= 1'b1;
                            r_out_result <= bus.init_acc;
                            r_out_flags  <= mk_flags(4'd0, bus.init_acc);
                        end else begin
                            r_state    <= S_ACCEPT;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_ACCEPT: begin
                    if (bus.in_valid) begin
                        r_fma_a    <= bus.in_a;
                        r_fma_b    <= bus.in_b;
                        r_fma_c    <= r_acc;
                        r_wcnt     <= WC_INIT;
                        r_in_ready <= 1'b0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wcnt != '0) begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end else begin
                        r_rem    <= r_rem - 1'b1;
                        r_sticky <= w_sticky;
`ifdef BF16_DOT_NAN_EARLY_EN
                        if (w_flags[3] | w_flags[2]) begin
                            r_acc <= QNAN;
                            if (w_last) begin
                                r_state      <= S_DONE;
                                r_out_valid  <= 1'b1;
                                r_out_result <= QNAN;
                                r_out_flags  <= mk_flags(w_sticky, QNAN);
                            end else begin
                                r_state    <= S_DRAIN;
                                r_in_ready <= 1'b1;
                            end
                        end else
`endif
                        begin
                            r_acc <= bus.fma_result;
                            if (w_last) begin
                                r_state      <= S_DONE;
                                r_out_valid  <= 1'b1;
                                r_out_result <= bus.fma_result;
                                r_out_flags  <= mk_flags(w_sticky,
                                                         bus.fma_result);
                            end else begin
                                r_state    <= S_ACCEPT;
                                r_in_ready <= 1'b1;
                            end
                        end
                    end
                end
`ifdef BF16_DOT_NAN_EARLY_EN
                S_DRAIN: begin
                    if (bus.in_valid) begin
                        r_rem <= r_rem - 1'b1;
                        if (w_last) begin
                            r_state      <= S_DONE;
                            r_in_ready   <= 1'b0;
                            r_out_valid  <= 1'b1;
                            r_out_result <= r_acc;
                            r_out_flags  <= mk_flags(r_sticky, r_acc);
                        end
                    end
                end
`endif
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.fma_a      = r_fma_a;
    assign bus.fma_b      = r_fma_b;
    assign bus.fma_c      = r_fma_c;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_flags  = r_out_flags;
    assign bus.busy       = r_busy;
endmodule

// File: doc/bf16_dot_sequencer.md
Name: bf16_dot_sequencer

Overview:
- Sequential controller placed directly upstream of the combinational bfloat16 FMA (A*B+C).
- Accepts a stream of bf16 operand pairs over a valid/ready handshake and drives the FMA operand ports from registers.
- Feeds each FMA result back in as the next C operand, so it computes init + sum(a_i*b_i).
- Presents the final dot-product result and accumulated exception flags on an output handshake.

Parameters:
- LEN_W, 8: width of the vector-length field; up to 2^LEN_W-1 pairs per job.
- FMA_LAT, 1: cycles from the operand-register update to sampling fma_result; minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- vec_len  in  LEN_W  number of pairs in the job; sampled with start.
- init_acc  in  16  initial accumulator value (bf16); sampled with start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer accepts a pair.
- in_a, in_b  in  16 each  operand pair (bf16).
- fma_a, fma_b, fma_c  out  16 each  registered operands to the FMA.
- fma_result  in  16  FMA result.
- fma_zero, fma_underflow, fma_overflow, fma_qnan, fma_snan  in  1 each  FMA flags.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_result  out  16  final accumulator value.
- out_flags  out  5  {snan, qnan, overflow, underflow, zero}.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset:
  - state=IDLE.
  - Registered outputs clear: fma_a, fma_b, fma_c, out_result and out_flags all 0.
  - in_ready, out_valid and busy are 0; the pair counter, wait counter and sticky flags are 0.
- Flag inputs: a flag counts as set only when it equals 1'b1. X or Z on a flag input counts as 0, because the FMA drives x when a flag is inactive.
- IDLE:
  - On start: remaining<=vec_len, acc<=init_acc, sticky<=0.
  - Go to DONE if vec_len==0, otherwise go to ACCEPT.
  - start is ignored in every other state.
- ACCEPT:
  - in_ready=1.
  - On in_valid&&in_ready: fma_a<=in_a, fma_b<=in_b, fma_c<=acc, wcnt<=FMA_LAT-1, go to WAIT.
- WAIT:
  - in_ready=0.
  - If wcnt!=0: wcnt<=wcnt-1.
  - Else: acc<=fma_result; sticky{snan,qnan,ovf,unf}|=flags; remaining<=remaining-1.
  - Then go to DONE if remaining==1, otherwise go to ACCEPT.
- Throughput: one pair per FMA_LAT+1 cycles. in_ready is high for exactly one cycle per pair when in_valid is already high.
- DONE:
  - out_valid=1; out_result=acc.
  - out_flags={sticky[3:0], acc[14:0]==0}; the zero bit reflects the final value only.
  - out_result and out_flags hold stable while out_valid && !out_ready.
  - On out_ready: go to IDLE; out_valid drops the next cycle.
  - A start arriving in the same cycle as out_ready is ignored.
- fma_a, fma_b and fma_c hold their last values outside updates, so the FMA inputs are glitch-free across waits.
- Reset mid-job: the job is abandoned, out_valid is never asserted for it, and all state returns to reset values.
- Counter arithmetic is unsigned. remaining never wraps because DONE is entered at 1.

Optional Feature:
Macro: BF16_DOT_NAN_EARLY_EN.
- Defined:
  - When the sampled fma_qnan or fma_snan is 1, enter DRAIN instead of ACCEPT, with acc<=16'h7FC0.
  - DRAIN holds in_ready=1 and consumes and discards the remaining pairs, one per cycle, without updating the fma_* registers.
  - When remaining reaches 0, go to DONE with out_result=16'h7FC0 and the sticky NaN bit set.
  - If the NaN occurs on the last pair, go straight to DONE.
- Undefined: there is no DRAIN state, and every pair is processed through the FMA regardless of NaNs.

Test Plan:
1. FMA_LAT=1, init_acc=16'h0000, vec_len=2, pairs (3F80,4000),(4000,4000), in_valid held high.
   -> handshakes spaced 2 cycles apart; fma_c=0000 then 4000; out_result=16'h40C0; out_flags=0.
2. vec_len=0, init_acc=16'h4040.
   -> in_ready never asserts; out_valid 1 cycle after start; out_result=4040; zero bit=0.
3. out_ready held low 5 cycles in DONE, and a start pulse issued during DONE.
   -> out_result and out_flags are stable for all 5 cycles; the start is ignored; IDLE follows the out_ready cycle.
4. Pair (7F00,7F00) with init 0.
   -> overflow sticky bit set in out_flags and kept through a following normal pair (3F80,3F80).
5. rst asserted in WAIT mid-job, then a new job with vec_len=1, (4000,4040), init 3F80.
   -> no out_valid from the aborted job; second result=16'h40E0.
6. FMA_LAT=3, vec_len=3.
   -> handshakes 4 cycles apart; fma_result is sampled on the 3rd WAIT cycle.
   -> with BF16_DOT_NAN_EARLY_EN and a qNaN pair first, the other 2 pairs are consumed on consecutive cycles and the result is 7FC0.
